// File: rtl/hex_ascii_uart_tx_if.sv
// Word-input bus of hex_ascii_uart_tx: the valid/ready handshake that carries
// one binary word into the serializer, plus a read-only view of the FSM state.
//
// Handshake: the producer drives in_data/in_valid, the serializer drives
// in_ready. A word transfers on a rising clk edge where in_valid && in_ready.
// in_ready is high only while the serializer is idle. A word offered while
// in_ready is low is neither taken nor remembered.
interface hex_ascii_uart_tx_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        dbg_state;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  dbg_state
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output dbg_state
    );
endinterface

// File: rtl/hex_ascii_uart_tx.sv
// hex_ascii_uart_tx: accepts one word, prints it as uppercase hex ASCII
// (optional "0x" prefix, optional CR/LF) on an 8N1 UART line with a built-in
// baud counter. Characters are sent back to back with no idle gap.
module hex_ascii_uart_tx #(
    parameter int DATA_W       = 32,
    parameter int CLKS_PER_BIT = 434,
    parameter int PREFIX_0X    = 0,
    parameter int APPEND_CRLF  = 1
) (
    input  logic            clk,
    input  logic            reset,
    hex_ascii_uart_tx_if.slave s_if,
    output logic            tx,
    output logic            busy,
    output logic            done
);

    localparam int ND     = DATA_W / 4;
    localparam int PFX_N  = 2 * PREFIX_0X;
    localparam int CRLF_N = 2 * APPEND_CRLF;
    localparam int NCHARS = PFX_N + ND + CRLF_N;
    localparam int CIW    = $clog2(NCHARS + 1);
    localparam int BW     = $clog2(CLKS_PER_BIT);

    localparam logic [CIW-1:0] LAST_IDX  = CIW'(NCHARS - 1);
    localparam logic [CIW-1:0] IDX_SAT   = CIW'(NCHARS);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    // Reject parameter sets that cannot produce a well-formed message.
    if ((DATA_W % 4) != 0 || DATA_W < 4) begin : g_bad_data_w
        $error("hex_ascii_uart_tx: DATA_W must be a non-zero multiple of 4");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("hex_ascii_uart_tx: CLKS_PER_BIT must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [CIW-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [7:0]        char_q, char_d;
    logic              tx_q, tx_d;

    logic              baud_last;
    logic [DATA_W-1:0] src_word;
    logic [CIW-1:0]    load_idx;
    logic [7:0]        char_load;
    logic [DATA_W-1:0] shift_load;

    // True when message position idx is one of the hex digits.
    function automatic logic is_digit(input logic [CIW-1:0] idx);
        int i;
        i = int'(idx);
        return (i >= PFX_N) && (i < PFX_N + ND);
    endfunction

    // ASCII code of message position idx; nib is the next unsent nibble.
    function automatic logic [7:0] char_for(input logic [CIW-1:0] idx,
                                            input logic [3:0]     nib);
        int i;
        i = int'(idx);
        if (i < PFX_N)
            return idx[0] ? 8'h78 : 8'h30;
        else if (i < PFX_N + ND)
            return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        else if (i == PFX_N + ND)
            return 8'h0D;
        else
            return 8'h0A;
    endfunction

    assign baud_last      = (baud_q == BAUD_LAST);
    assign s_if.in_ready  = (state_q == IDLE);
    assign s_if.dbg_state = state_q;
    assign busy           = (state_q != IDLE);
    assign tx             = tx_q;

    // Next character: taken from the input word at acceptance, otherwise from
    // the shift register, which drops one nibble per hex digit consumed.
    always_comb begin
        src_word   = (state_q == IDLE) ? s_if.in_data : shift_q;
        load_idx   = (state_q == IDLE) ? '0 : (idx_q + 1'b1);
        char_load  = char_for(load_idx, src_word[DATA_W-1 -: 4]);
        shift_load = is_digit(load_idx) ? (src_word << 4) : src_word;
    end

    // Next-state logic: frame sequencing, baud/bit/char counters, done pulse.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        char_d  = char_q;
        done    = 1'b0;
        tx_d    = 1'b1;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (s_if.in_valid) begin
                    idx_d   = '0;
                    char_d  = char_load;
                    shift_d = shift_load;
                    state_d = START;
                end
            end
            START: begin
                baud_d = baud_last ? '0 : (baud_q + 1'b1);
                if (baud_last) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                baud_d = baud_last ? '0 : (baud_q + 1'b1);
                if (baud_last) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7)
                        state_d = STOP;
                end
            end
            STOP: begin
                baud_d = baud_last ? '0 : (baud_q + 1'b1);
                if (baud_last) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = IDX_SAT;
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = load_idx;
                        char_d  = char_load;
                        shift_d = shift_load;
                        state_d = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = char_d[bit_d];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset aborts any message in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            char_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            char_q  <= char_d;
            tx_q    <= tx_d;
        end
    end

endmodule
